bin_to_bcd_seq: RTL
===================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter using double-dabble, one shift per clock.
//  Sits directly upstream of the 7-segment LUT stage.
//  oBCD nibble k feeds the iDIG[3:0] input of digit-k decoder; oDONE drives their iWR strobe.
//  Lets software/HPS write a plain binary count and see it displayed in decimal.
// PARAMETERS
//  BIN_W   20  width of binary input (>=4)
//  DIGITS  6   number of BCD output digits (>=1); MAXV = 10**DIGITS-1 (localparam)
// PORTS
//  iCLK     in   1           single clock; all logic on posedge
//  iRST_N   in   1           synchronous, active-low reset
//  iSTART   in   1           request conversion of iBIN; sampled on posedge
//  iBIN     in   BIN_W       binary value (unsigned; two's complement if SIGNED_EN)
//  oBUSY    out  1           1 while in SHIFT state
//  oDONE    out  1           1-cycle pulse: oBCD/oOVF/oNEG updated this cycle
//  oBCD     out  4*DIGITS    packed BCD, digit 0 (units) in [3:0]
//  oOVF     out  1           value exceeded MAXV; oBCD saturated to all 9s
//  oNEG     out  1           input was negative (SIGNED_EN only; else tied 0)
// BEHAVIOUR
//  Reset (iRST_N=0 at posedge): state=IDLE, oBUSY=0, oDONE=0, oBCD=0, oOVF=0, oNEG=0.
//   Reset mid-conversion aborts it; no oDONE is produced for the aborted value.
//  FSM: IDLE -> SHIFT on iSTART; SHIFT -> DONE after BIN_W shifts; DONE -> IDLE,
//   or DONE -> SHIFT if iSTART=1 in the DONE cycle (back-to-back accepted).
//  Accept: iSTART sampled only in IDLE or DONE; ignored in SHIFT (no queueing).
//   On accept, iBIN (magnitude if SIGNED_EN) latched to shift reg; BCD scratch cleared;
//   ovf flag = (magnitude > MAXV), latched.
//  SHIFT: each cycle, every scratch nibble >=5 gets +3, then {scratch,shreg} <<= 1.
//   Scratch holds DIGITS+2 nibbles internally so no intermediate overflow is possible.
//   A BIN_W-bit counter runs from 0; exit at count BIN_W-1.
//  Latency: accepted at edge k -> oDONE=1 in cycle after edge k+BIN_W+1.
//   Fixed; overflow does not shorten it. Throughput: 1 result per BIN_W+1 cycles.
//  DONE: oBCD <= ovf ? {DIGITS{4'h9}} : low DIGITS nibbles of scratch.
//   oOVF/oNEG loaded in the same cycle; all three held until the next DONE or reset.
//  oBCD only ever carries nibbles 0..9 (downstream hex glyphs A-F never shown).
//  Boundaries: iBIN=0 -> all zero digits; iBIN=MAXV -> all 9s, oOVF=0;
//   MAXV+1 -> all 9s, oOVF=1; iBIN all-ones -> oOVF=1 when 2**BIN_W-1 > MAXV.
// CONFIGURATION
//  SIGNED_EN defined: iBIN is two's complement.
//   On accept, magnitude = iBIN[BIN_W-1] ? -iBIN : iBIN, held in a BIN_W-bit register.
//   -2**(BIN_W-1) converts to 2**(BIN_W-1) without wrap. oNEG <= sign in DONE.
//   -0 does not occur; oNEG=0 for zero.
//  SIGNED_EN undefined: iBIN is unsigned; oNEG is constant 0; no negation logic.
// TESTING
//  1. Reset, iSTART with iBIN=0 -> 21 cycles later oDONE=1, oBCD=24'h000000, oOVF=0.
//  2. iBIN=123456 -> oBCD=24'h123456. oDONE high exactly 1 cycle. oBUSY high 20 cycles.
//  3. iBIN=999999 -> 24'h999999, oOVF=0; then iBIN=1000000 -> 24'h999999, oOVF=1;
//     iBIN=20'hFFFFF -> 24'h999999, oOVF=1.
//  4. iSTART=1 every cycle with iBIN=42, then 77:
//     one result per 21 cycles; mid-SHIFT starts ignored; DONE-cycle start accepted.
//  5. iRST_N=0 for 1 cycle at SHIFT cycle 10 -> no oDONE; outputs zero.
//     Next start (iBIN=7) -> 24'h000007.
//  6. SIGNED_EN: iBIN=-524288 -> oBCD=24'h524288, oNEG=1;
//     iBIN=-1 -> 24'h000001, oNEG=1; iBIN=5 -> oNEG=0.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one shift per clock).
// Optional feature: define SIGNED_EN to treat iBIN as two's complement and report oNEG.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  iSTART,
  input  logic [BIN_W-1:0]      iBIN,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic [4*DIGITS-1:0]   oBCD,
  output logic                  oOVF,
  output logic                  oNEG
);

  localparam longint unsigned MAXV = (64'd10 ** DIGITS) - 64'd1;
  // Two spare nibbles keep the add-3/shift free of intermediate overflow.
  localparam int SW = 4 * (DIGITS + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [BIN_W-1:0]       shReg;
  logic [BIN_W-1:0]       cnt;
  logic [BIN_W-1:0]       mag;
  logic [SW-1:0]          scratch;
  logic [SW-1:0]          adj;
  logic [SW+BIN_W-1:0]    shifted;
  logic                   ovf;

`ifdef SIGNED_EN
  logic                   neg;
  // -(-2**(BIN_W-1)) wraps to 2**(BIN_W-1), which is exactly the unsigned magnitude.
  assign mag = iBIN[BIN_W-1] ? -iBIN : iBIN;
`else
  assign mag  = iBIN;
  assign oNEG = 1'b0;
`endif

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS + 2; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    shifted = {adj, shReg} << 1;
  end

  // NOTE: sequential state uses non-blocking assignments only; the DONE branch reads
  // scratch/ovf while a back-to-back accept reloads them in the same edge.
  // NOTE: shReg/scratch are pure datapath, always reloaded on accept, so they carry no reset.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state <= IDLE;
      oBUSY <= 1'b0;
      oDONE <= 1'b0;
      oBCD  <= '0;
      oOVF  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
`ifdef SIGNED_EN
      oNEG  <= 1'b0;
      neg   <= 1'b0;
`endif
    end else begin
      oDONE <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            oDONE <= 1'b1;
            oBCD  <= ovf ? {DIGITS{4'h9}} : scratch[4*DIGITS-1:0];
            oOVF  <= ovf;
`ifdef SIGNED_EN
            oNEG  <= neg;
`endif
          end
          if (iSTART) begin
            state   <= SHIFT;
            oBUSY   <= 1'b1;
            shReg   <= mag;
            scratch <= '0;
            cnt     <= '0;
            ovf     <= (64'(mag) > MAXV);
`ifdef SIGNED_EN
            neg     <= iBIN[BIN_W-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          scratch <= shifted[SW+BIN_W-1:BIN_W];
          shReg   <= shifted[BIN_W-1:0];
          cnt     <= cnt + 1'b1;
          if (cnt == BIN_W'(BIN_W - 1)) begin
            state <= DONE;
            oBUSY <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
